// File: rtl/pwm_duty_update_scheduler.sv
// pwm_duty_update_scheduler
// Round-robin arbiter feeding per-slot shadow registers (duty ch0..2, period)
// that are committed to the PWM core outputs only at period boundaries, or
// on every edge while the core is disabled.
// Optional build macro: PWM_RAMP_EN -- duty slots slew toward their shadow
// target by at most RAMP_STEP per commit instead of jumping.
module pwm_duty_update_scheduler #(
  parameter int                   PWM_WIDTH      = 12,
  parameter int                   NUM_REQ        = 3,
  parameter logic [PWM_WIDTH-1:0] DEFAULT_PERIOD = 12'hFFF,
  parameter int                   RAMP_STEP      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [2*NUM_REQ-1:0]           req_slot,
  input  logic [PWM_WIDTH*NUM_REQ-1:0]   req_value,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           pwm_enable,
  input  logic                           period_complete,
  output logic [PWM_WIDTH-1:0]           duty_cycle_ch0,
  output logic [PWM_WIDTH-1:0]           duty_cycle_ch1,
  output logic [PWM_WIDTH-1:0]           duty_cycle_ch2,
  output logic [PWM_WIDTH-1:0]           period_value,
  output logic [3:0]                     pending,
  output logic                           commit_pulse
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] PERIOD_SLOT = 2'd3;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_nxt;
  logic                 xfer;
  logic [PTR_W-1:0]     grant_idx;
  logic [1:0]           xfer_slot;
  logic [PWM_WIDTH-1:0] xfer_value;

  logic [PWM_WIDTH-1:0] shadow     [4];
  logic [PWM_WIDTH-1:0] active     [4];
  logic [PWM_WIDTH-1:0] active_nxt [4];
  logic [3:0]           pending_q;
  logic [3:0]           pending_nxt;
  logic                 commit_now;
  logic                 commit_any;

`ifdef PWM_RAMP_EN
  // Move cur toward tgt by at most RAMP_STEP, never overshooting.
  function automatic logic [PWM_WIDTH-1:0] ramp_toward(
    input logic [PWM_WIDTH-1:0] cur,
    input logic [PWM_WIDTH-1:0] tgt
  );
    logic [PWM_WIDTH-1:0] step;
    step = PWM_WIDTH'(RAMP_STEP);
    if (tgt > cur)
      ramp_toward = ((tgt - cur) > step) ? cur + step : tgt;
    else
      ramp_toward = ((cur - tgt) > step) ? cur - step : tgt;
  endfunction
`endif

  // Round-robin grant: first valid requester at or after rr_ptr, then wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    req_ready  = '0;
    xfer       = 1'b0;
    grant_idx  = '0;
    xfer_slot  = '0;
    xfer_value = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!xfer && req_valid[i] && (i >= int'(rr_ptr))) begin
          xfer       = 1'b1;
          grant_idx  = PTR_W'(i);
          xfer_slot  = req_slot[2*i +: 2];
          xfer_value = req_value[PWM_WIDTH*i +: PWM_WIDTH];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!xfer && req_valid[i] && (i < int'(rr_ptr))) begin
          xfer       = 1'b1;
          grant_idx  = PTR_W'(i);
          xfer_slot  = req_slot[2*i +: 2];
          xfer_value = req_value[PWM_WIDTH*i +: PWM_WIDTH];
        end
      end
      if (xfer) req_ready[grant_idx] = 1'b1;
    end
  end

  // Pointer advances past the granted requester only when a transfer happens.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (xfer)
      rr_ptr_nxt = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

  // Commit decision per slot; commits read the old shadow, a same-edge
  // transfer re-arms pending for the next boundary.
  always_comb begin
    commit_now = pwm_enable ? period_complete : 1'b1;
    commit_any = commit_now && (|pending_q);
    for (int s = 0; s < 4; s++) begin
      active_nxt[s]  = active[s];
      pending_nxt[s] = pending_q[s];
      if (commit_now && pending_q[s]) begin
`ifdef PWM_RAMP_EN
        if (s == 3) begin
          active_nxt[s]  = shadow[s];
          pending_nxt[s] = 1'b0;
        end else begin
          active_nxt[s]  = ramp_toward(active[s], shadow[s]);
          pending_nxt[s] = (active_nxt[s] != shadow[s]);
        end
`else
        active_nxt[s]  = shadow[s];
        pending_nxt[s] = 1'b0;
`endif
      end
      if (xfer && (xfer_slot == 2'(s))) pending_nxt[s] = 1'b1;
    end
  end

  // State registers: pointer, shadows, active outputs, pending, commit pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      pending_q    <= '0;
      commit_pulse <= 1'b0;
      // NOTE: the shadow array is reset too, so a stale value can never be committed after reset.
      for (int s = 0; s < 4; s++) shadow[s] <= '0;
      for (int s = 0; s < 3; s++) active[s] <= '0;
      active[3]    <= DEFAULT_PERIOD;
    end else begin
      // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
      rr_ptr       <= rr_ptr_nxt;
      pending_q    <= pending_nxt;
      commit_pulse <= commit_any;
      for (int s = 0; s < 4; s++) active[s] <= active_nxt[s];
      if (xfer) begin
        // A zero period would stall the core, so it is stored as 1.
        if ((xfer_slot == PERIOD_SLOT) && (xfer_value == '0))
          shadow[xfer_slot] <= PWM_WIDTH'(1);
        else
          shadow[xfer_slot] <= xfer_value;
      end
    end
  end

  assign duty_cycle_ch0 = active[0];
  assign duty_cycle_ch1 = active[1];
  assign duty_cycle_ch2 = active[2];
  assign period_value   = active[3];
  assign pending        = pending_q;

endmodule
